// File: rtl/clk_reset_seq.sv
// Reset sequencer and clock-enable generator behind the core PLL: qualifies lock, releases sys_rst_n, emits ce_vid/ce_cpu.
// Optional feature: define CLK_RESET_SEQ_PAUSE_EN to let `pause` gate ce_cpu (otherwise the port is ignored).
module clk_reset_seq #(
    parameter int unsigned STABLE_CYCLES = 4096,
    parameter int unsigned DIV_VID       = 2,
    parameter int unsigned DIV_CPU       = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic locked,
    input  logic pause,
    output logic sys_rst_n,
    output logic ce_vid,
    output logic ce_cpu,
    output logic running
);

    localparam int STB_W = $clog2(STABLE_CYCLES);
    localparam int VID_W = $clog2(DIV_VID);
    localparam int CPU_W = $clog2(DIV_CPU);

    localparam logic [STB_W-1:0] STB_LAST = STB_W'(STABLE_CYCLES - 1);
    localparam logic [VID_W-1:0] VID_LAST = VID_W'(DIV_VID - 1);
    localparam logic [CPU_W-1:0] CPU_LAST = CPU_W'(DIV_CPU - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABILIZE = 2'd1,
        RUN       = 2'd2
    } state_t;

    state_t             state;
    state_t             nxt;
    logic               go_run;
    logic               sync_p0;
    logic               lock_s;
    logic               pause_eff;
    logic [STB_W-1:0]   stb_cnt;
    logic [VID_W-1:0]   cnt_vid;
    logic [CPU_W-1:0]   cnt_cpu;

`ifdef CLK_RESET_SEQ_PAUSE_EN
    assign pause_eff = pause;
`else
    logic unused_pause;
    assign unused_pause = pause;
    assign pause_eff    = 1'b0;
`endif

    function automatic state_t next_state(input state_t cur, input logic lk,
                                          input logic [STB_W-1:0] cnt);
        case (cur)
            WAIT_LOCK: next_state = lk ? STABILIZE : WAIT_LOCK;
            STABILIZE: begin
                if (!lk)                  next_state = WAIT_LOCK;
                else if (cnt == STB_LAST) next_state = RUN;
                else                      next_state = STABILIZE;
            end
            RUN:       next_state = lk ? RUN : WAIT_LOCK;
            default:   next_state = WAIT_LOCK;
        endcase
    endfunction

    // Outputs and dividers follow the next state so release, lock loss and
    // the enables all line up on the same clock edge.
    assign nxt    = next_state(state, lock_s, stb_cnt);
    assign go_run = (nxt == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0   <= 1'b0;
            lock_s    <= 1'b0;
            state     <= WAIT_LOCK;
            stb_cnt   <= '0;
            cnt_vid   <= '0;
            cnt_cpu   <= '0;
            sys_rst_n <= 1'b0;
            running   <= 1'b0;
            ce_vid    <= 1'b0;
            ce_cpu    <= 1'b0;
        end else begin
            sync_p0   <= locked;
            lock_s    <= sync_p0;
            state     <= nxt;
            sys_rst_n <= go_run;
            running   <= go_run;

            if (state == STABILIZE && nxt == STABILIZE)
                stb_cnt <= stb_cnt + 1'b1;
            else
                stb_cnt <= '0;

            if (!go_run)
                cnt_vid <= '0;
            else if (cnt_vid == VID_LAST)
                cnt_vid <= '0;
            else
                cnt_vid <= cnt_vid + 1'b1;

            // cnt_cpu keeps running through a pause so the CPU phase is kept
            if (!go_run)
                cnt_cpu <= '0;
            else if (cnt_cpu == CPU_LAST)
                cnt_cpu <= '0;
            else
                cnt_cpu <= cnt_cpu + 1'b1;

            ce_vid <= go_run && (cnt_vid == VID_LAST);
            ce_cpu <= go_run && (cnt_cpu == CPU_LAST) && !pause_eff;
        end
    end

endmodule

// File: doc/clk_reset_seq.md
# clk_reset_seq

Reset sequencer and clock-enable generator directly downstream of the core PLL. It runs on the PLL's 12 MHz output and qualifies the PLL lock indication. It holds the core in reset until lock has been stable for a programmable time, then releases a synchronised reset. It also produces the single-cycle clock enables (6 MHz video, 1.5 MHz CPU) that the rest of the core uses instead of derived clocks.

## Interface
Parameters:
- `STABLE_CYCLES`, default 4096: consecutive synchronised-lock cycles required before reset release; range 2..65535.
- `DIV_VID`, default 2: video enable divider; ≥2.
- `DIV_CPU`, default 8: CPU enable divider; ≥2, integer multiple of `DIV_VID`.

Ports:
- `clk`, in, 1: 12 MHz PLL output; the only clock.
- `rst_n`, in, 1: asynchronous, active-low reset (user/system reset).
- `locked`, in, 1: PLL lock; asynchronous to `clk`.
- `pause`, in, 1: synchronous to `clk`; freezes CPU enable (see Configuration).
- `sys_rst_n`, out, 1: active-low core reset, registered; deasserts synchronously.
- `ce_vid`, out, 1: one-cycle video enable.
- `ce_cpu`, out, 1: one-cycle CPU enable.
- `running`, out, 1: high when the state machine is in RUN.

## Operation
- **Lock synchroniser.** `locked` passes through a 2-flop synchroniser, giving `lock_s`. Both flops clear on `rst_n` low.
- **State machine.** Asserting `rst_n` (low) forces WAIT_LOCK from any state.
  - WAIT_LOCK: stable counter held at 0. When `lock_s`=1, go to STABILIZE.
  - STABILIZE: counter increments each cycle while `lock_s`=1. If `lock_s`=0, return to WAIT_LOCK and clear the counter. When the counter reaches `STABLE_CYCLES-1`, go to RUN.
  - RUN: if `lock_s`=0, go to WAIT_LOCK immediately.
- **Reset output.** `sys_rst_n` = 1 only while in RUN; it is registered from the next-state value.
- **Dividers.** `cnt_vid` (0..`DIV_VID-1`) and `cnt_cpu` (0..`DIV_CPU-1`) are held at 0 outside RUN. In RUN they increment and wrap to 0.
- **Enables.** Both are registered.
  - `ce_vid` <= RUN && `cnt_vid`==`DIV_VID-1`.
  - `ce_cpu` <= RUN && `cnt_cpu`==`DIV_CPU-1` && !pause_eff.
  - Because `DIV_CPU` is a multiple of `DIV_VID`, every `ce_cpu` pulse coincides with a `ce_vid` pulse.
- **Counter widths.** Each counter is $clog2 of its maximum value + 1. No overflow is possible, since every counter is compared against its terminal value before it increments.

## Timing
- Reset values (with `rst_n` low): `sys_rst_n`=0, `ce_vid`=0, `ce_cpu`=0, `running`=0, state WAIT_LOCK, all counters 0.
- Lock-to-release latency: `locked` rising → `sys_rst_n` rising in 2 (sync) + 1 (WAIT_LOCK→STABILIZE) + `STABLE_CYCLES` cycles. This is 4099 cycles at the default.
- `running` and `sys_rst_n` change in the same cycle.
- Lock loss: `locked` falling → `sys_rst_n`=0 after 3 cycles (2 sync + 1 register). `ce_*` stop in that same cycle and the divider counters return to 0.
- First enables after release: with `sys_rst_n` rising at cycle T, the first `ce_vid` is at T+`DIV_VID`-1 and the first `ce_cpu` is at T+`DIV_CPU`-1. The defaults give T+1 and T+7.
- Lock glitches: a glitch shorter than `STABLE_CYCLES` during STABILIZE restarts the count from 0.
- Mid-operation reset: `rst_n` asserted in any state clears all outputs asynchronously. After `rst_n` deasserts, the full lock sequence repeats; the synchroniser also restarts from 0.
- Pause: `pause` sampled high in cycle N suppresses any `ce_cpu` that would appear in cycle N+1. `cnt_cpu` keeps counting, so CPU phase is preserved across a pause. `ce_vid` is never affected.

## Configuration
- `CLK_RESET_SEQ_PAUSE_EN` defined: `pause` gates `ce_cpu` as described above (pause_eff = `pause`).
- Not defined: the `pause` port remains but is ignored (pause_eff = 0), and `ce_cpu` runs continuously in RUN.

## Test plan
- Power-up: `rst_n` low for 5 cycles, `locked`=0 → all outputs 0. Release `rst_n`, raise `locked` → `sys_rst_n` and `running` rise exactly 4099 cycles after `locked` rises.
- Glitch: `locked` drops for 3 cycles at STABILIZE count 2000 → the counter restarts. Release occurs 4099 cycles after the final `locked` rise.
- Enables: in RUN with the defaults → `ce_vid` period is 2 cycles and `ce_cpu` period is 8 cycles. Every `ce_cpu` coincides with `ce_vid`. First pulses land at T+1 and T+7.
- Lock loss in RUN: `locked` falls → `sys_rst_n`=0 three cycles later, with no `ce_*` from that cycle onward.
- Pause (macro defined): `pause` high for 20 cycles → no `ce_cpu` pulses in that window, and the next pulse stays on its original 8-cycle grid. With the macro undefined, `ce_cpu` is unaffected.
- Async reset mid-RUN: `rst_n` pulsed low for half a cycle → outputs clear immediately, and the full 4099-cycle sequence repeats.
